dmi_bridge_queue: RTL
=====================

// Module: dmi_bridge_queue
// PURPOSE
// Parametrised, synthesizable DMI transport bridge between a host command stream and the
// debug module's DMI req/resp channels. Buffers commands, keeps up to MAX_OUT requests in
// flight with guaranteed response space, and queues responses back to the host.
// Adds a response timeout watchdog and an in-band exit command that latches an exit code.
// Sits where the simulation DTM sits, so the design can be driven by JTAG, UART or a DPI host.
// PARAMETERS
// ADDR_W     7     DMI address width
// CMD_DEPTH  4     command FIFO entries (power of 2, >=2)
// RSP_DEPTH  4     response FIFO entries (power of 2, >=MAX_OUT)
// MAX_OUT    2     max outstanding DMI requests (>=1)
// TIMEOUT    1024  cycles without a response while outstanding>0 before timeout; 0 disables
// PORTS
// clk                  in   1          clock
// reset                in   1          synchronous, active-high reset
// host_req_valid       in   1          host command valid
// host_req_ready       out  1          host command accepted when valid&ready
// host_req_addr        in   ADDR_W     command address
// host_req_op          in   2          0 nop, 1 read, 2 write, 3 exit (never forwarded)
// host_req_data        in   32         write data / exit code
// debug_req_valid      out  1          DMI request valid
// debug_req_ready      in   1          DMI request ready
// debug_req_bits_addr  out  ADDR_W     DMI address
// debug_req_bits_op    out  2          DMI op (0..2 only)
// debug_req_bits_data  out  32         DMI data
// debug_resp_valid     in   1          DMI response valid
// debug_resp_ready     out  1          DMI response ready
// debug_resp_bits_resp in   2          DMI response code
// debug_resp_bits_data in   32         DMI response data
// host_resp_valid      out  1          response to host valid
// host_resp_ready      in   1          host accepts response
// host_resp_resp       out  2          queued resp code
// host_resp_data       out  32         queued resp data
// outstanding          out  $clog2(MAX_OUT+1)  requests issued, not yet answered
// timeout              out  1          sticky: watchdog expired
// exit                 out  32         0 = running; else {code[30:0],1'b1}
// BEHAVIOUR
// - Reset: reset and the registered copy r_reset both count as reset ("rst2"). During rst2:
//   FIFOs empty, outstanding=0, watchdog=0, timeout=0, exit=0, host_req_ready=0,
//   debug_req_valid=0, host_resp_valid=0, debug_resp_ready=1 (stray responses dropped).
// - host_req_ready = !cmd_full && exit==0 && !timeout. Enqueue at t -> head visible t+1.
// - Issue: debug_req_valid = !cmd_empty && head.op!=3 && outstanding<MAX_OUT &&
//   (outstanding+rsp_count)<RSP_DEPTH && !timeout. Bits driven from head; stable while
//   valid&!ready. Pop head and outstanding+1 on fire.
// - Exit cmd at head: waits until outstanding==0 and rsp FIFO empty, then pops;
//   exit <= {data[30:0],1'b1} the next cycle. Commands behind it are never issued.
// - debug_resp_ready = !rsp_full (always 1 by credit rule). Resp fire at t -> pushed,
//   host_resp_valid at t+1; outstanding-1 at fire. Req and resp fire same cycle: unchanged.
// - Resp FIFO: push and pop in same cycle allowed when non-empty; count unchanged.
//   host_resp_* stable while valid&!ready. Pointers wrap modulo depth.
// - Watchdog: cleared when outstanding==0 or on resp fire; else +1/cycle. Reaching
//   TIMEOUT-1 sets timeout (sticky until reset) and, if exit==0, exit <= 32'h3.
//   After timeout: no issue, no host commands; late responses still queued to host.
// - Reset asserted mid-transaction: all state discarded per rst2 rules, no partial beats.
// TESTING
// - Write a=0x10 d=0xDEAD, ready=1 -> debug_req fire 1 cycle after host accept, op=2.
// - 4 reads, MAX_OUT=2, resp withheld -> exactly 2 issued, outstanding=2, 3rd waits.
// - host_resp_ready=0, 4 reads -> no issue beyond outstanding+rsp_count=4; no loss.
// - Read then exit code 5 -> read completes, host drains resp, then exit=32'hB, ready=0.
// - TIMEOUT=16, one read, no resp -> timeout=1 at 16th cycle, exit=32'h3, valid drops.
// - Reset 1 cycle mid-burst with resp arriving next cycle -> resp dropped, all outputs 0.

Source files
------------

// File: rtl/dmi_bridge_if.sv
// Handshake bundle between host stream, bridge and DMI debug module.
// master = bridge side, slave = host/debug-module environment side.
interface dmi_bridge_if #(
    parameter int ADDR_W = 7
);
    logic              host_req_valid;
    logic              host_req_ready;
    logic [ADDR_W-1:0] host_req_addr;
    logic [1:0]        host_req_op;
    logic [31:0]       host_req_data;

    logic              debug_req_valid;
    logic              debug_req_ready;
    logic [ADDR_W-1:0] debug_req_bits_addr;
    logic [1:0]        debug_req_bits_op;
    logic [31:0]       debug_req_bits_data;

    logic              debug_resp_valid;
    logic              debug_resp_ready;
    logic [1:0]        debug_resp_bits_resp;
    logic [31:0]       debug_resp_bits_data;

    logic              host_resp_valid;
    logic              host_resp_ready;
    logic [1:0]        host_resp_resp;
    logic [31:0]       host_resp_data;

    modport master (
        input  host_req_valid, host_req_addr, host_req_op, host_req_data,
        output host_req_ready,
        output debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        input  debug_req_ready,
        input  debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        output debug_resp_ready,
        output host_resp_valid, host_resp_resp, host_resp_data,
        input  host_resp_ready
    );

    modport slave (
        output host_req_valid, host_req_addr, host_req_op, host_req_data,
        input  host_req_ready,
        input  debug_req_valid, debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data,
        output debug_req_ready,
        output debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data,
        input  debug_resp_ready,
        input  host_resp_valid, host_resp_resp, host_resp_data,
        output host_resp_ready
    );
endinterface

// File: rtl/dmi_bridge_queue.sv
// DMI transport bridge: command FIFO -> DMI requests with credit-limited issue,
// response FIFO back to host, response watchdog and in-band exit command.
module dmi_bridge_queue #(
    parameter int ADDR_W    = 7,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int MAX_OUT   = 2,
    parameter int TIMEOUT   = 1024,
    localparam int OUT_W    = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    dmi_bridge_if.master     bus,
    output logic [OUT_W-1:0] outstanding,
    output logic             timeout,
    output logic [31:0]      exit
);
    localparam int CP_W = $clog2(CMD_DEPTH);
    localparam int RP_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CP_W:0]   CMD_FULL = (CP_W+1)'(CMD_DEPTH);
    localparam logic [RP_W:0]   RSP_FULL = (RP_W+1)'(RSP_DEPTH);
    localparam logic [CP_W:0]   CP_ONE   = (CP_W+1)'(1);
    localparam logic [RP_W:0]   RP_ONE   = (RP_W+1)'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
    // timeout is raised on the edge where the watchdog steps onto TIMEOUT-1
    localparam logic [WD_W-1:0] WD_LIM   = WD_W'((TIMEOUT > 1) ? TIMEOUT - 2 : 0);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        op;
        logic [31:0]       data;
    } cmd_t;

    cmd_t        cmd_mem [2**CP_W];
    logic [33:0] rsp_mem [2**RP_W];
    logic [CP_W:0] cmd_wr, cmd_rd;
    logic [RP_W:0] rsp_wr, rsp_rd, rsp_count;
    logic [WD_W-1:0] wd;

    logic r_reset, rst2;
    logic cmd_empty, cmd_full, rsp_empty, rsp_full, running, credit_ok;
    logic issue_ok, req_fire, exit_pop, cmd_push, cmd_pop;
    logic resp_fire, rsp_pop, out_dec, wd_hit;
    cmd_t head;

    // the cycle after reset deasserts is still treated as reset
    assign rst2      = reset | r_reset;
    assign head      = cmd_mem[cmd_rd[CP_W-1:0]];
    assign cmd_empty = (cmd_wr == cmd_rd);
    assign cmd_full  = ((cmd_wr - cmd_rd) == CMD_FULL);
    assign rsp_count = rsp_wr - rsp_rd;
    assign rsp_empty = (rsp_count == '0);
    assign rsp_full  = (rsp_count == RSP_FULL);
    assign running   = (exit == '0) && !timeout;
    // every in-flight request must have a guaranteed response slot
    assign credit_ok = (int'(outstanding) < MAX_OUT) &&
                       ((int'(outstanding) + int'(rsp_count)) < RSP_DEPTH);

    assign issue_ok  = !rst2 && !cmd_empty && (head.op != 2'd3) && running && credit_ok;
    assign req_fire  = issue_ok && bus.debug_req_ready;
    assign exit_pop  = !rst2 && !cmd_empty && (head.op == 2'd3) && running &&
                       (outstanding == '0) && rsp_empty;
    assign cmd_push  = bus.host_req_valid && bus.host_req_ready;
    assign cmd_pop   = req_fire || exit_pop;
    assign resp_fire = !rst2 && bus.debug_resp_valid && !rsp_full;
    assign rsp_pop   = bus.host_resp_valid && bus.host_resp_ready;
    assign out_dec   = resp_fire && (outstanding != '0);
    assign wd_hit    = (TIMEOUT != 0) && !rst2 && !timeout && (outstanding != '0) &&
                       !resp_fire && (wd >= WD_LIM);

    assign bus.host_req_ready      = !rst2 && !cmd_full && running;
    assign bus.debug_req_valid     = issue_ok;
    assign bus.debug_req_bits_addr = head.addr;
    assign bus.debug_req_bits_op   = head.op;
    assign bus.debug_req_bits_data = head.data;
    assign bus.debug_resp_ready    = rst2 || !rsp_full;
    assign bus.host_resp_valid     = !rst2 && !rsp_empty;
    assign bus.host_resp_resp      = rsp_mem[rsp_rd[RP_W-1:0]][33:32];
    assign bus.host_resp_data      = rsp_mem[rsp_rd[RP_W-1:0]][31:0];

    always_ff @(posedge clk) begin
        r_reset <= reset;
    end

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wr[CP_W-1:0]] <= '{bus.host_req_addr, bus.host_req_op, bus.host_req_data};
        if (resp_fire)
            rsp_mem[rsp_wr[RP_W-1:0]] <= {bus.debug_resp_bits_resp, bus.debug_resp_bits_data};
    end

    always_ff @(posedge clk) begin
        if (rst2) begin
            cmd_wr      <= '0;
            cmd_rd      <= '0;
            rsp_wr      <= '0;
            rsp_rd      <= '0;
            outstanding <= '0;
            wd          <= '0;
            timeout     <= 1'b0;
            exit        <= '0;
        end else begin
            if (cmd_push)  cmd_wr <= cmd_wr + CP_ONE;
            if (cmd_pop)   cmd_rd <= cmd_rd + CP_ONE;
            if (resp_fire) rsp_wr <= rsp_wr + RP_ONE;
            if (rsp_pop)   rsp_rd <= rsp_rd + RP_ONE;

            if (req_fire && !out_dec)
                outstanding <= outstanding + OUT_ONE;
            else if (!req_fire && out_dec)
                outstanding <= outstanding - OUT_ONE;

            if (outstanding == '0 || resp_fire)
                wd <= '0;
            else if (!timeout)
                wd <= wd + WD_ONE;

            if (exit_pop)
                exit <= {head.data[30:0], 1'b1};
            if (wd_hit) begin
                timeout <= 1'b1;
                if (exit == '0) exit <= 32'h3;
            end
        end
    end
endmodule
